// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader FSM state encoding, stream framing constants and a
// state decode helper used by the top level.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int HDR_BYTES  = 2;
   localparam int CNT_W      = $clog2(WORD_BYTES);

   // True in the states that consume bytes from the stream.
   function automatic logic rx_open(input state_t s);
      case (s)
         ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: rx_open = 1'b1;
         default:                                 rx_open = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, rst_n  - clock, async active-low reset (already synchronised)
//   clear       - restart assembly at byte 0 (new load session)
//   accept      - a data byte is transferred this cycle
//   data        - the data byte
//   last        - combinational: this accepted byte completes a word
//   word_valid  - registered one-cycle pulse, cycle after the 4th byte
//   word        - assembled word; holds its value until the next word completes
module byte_packer
   import loader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic [7:0]       data,
   output logic             last,
   output logic             word_valid,
   output logic [WIDTH-1:0] word
);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-9:0] partial;

   assign last = accept && (cnt == CNT_W'(WORD_BYTES - 1));

   // Byte counter, partial-word buffer and completed-word register.
   // The completed word is copied out so a byte arriving in the write
   // cycle can start the next word in the partial buffer without clobbering it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         partial    <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= last;
         if (clear) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (last) begin
               word <= {data, partial};
            end else begin
               partial[{cnt, 3'b000} +: 8] <= data;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream
// (LEN_LO, LEN_HI, 4*N data bytes, XOR checksum), writes the words to
// instruction memory and holds the CPU in reset until a verified load.
// Ports:
//   clk, reset (async active-low), start (session pulse)
//   rx_valid/rx_data/rx_ready - byte stream handshake
//   mem_we/mem_addr/mem_wdata - instruction memory write port (byte address)
//   cpu_hold, done, error     - status
module imem_loader
#(
   parameter int WIDTH = 32,
   parameter int SIZE  = 102
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);
   import loader_pkg::*;

   localparam logic [15:0] SIZE_W = 16'(SIZE);

   logic [1:0]  rst_sync;
   logic        rst_n;
   state_t      state;
   state_t      state_next;
   logic [7:0]  len_lo;
   logic [15:0] n_words;
   logic [15:0] n_hdr;
   logic [15:0] word_idx;
   logic [7:0]  csum;
   logic        xfer;
   logic        start_ok;
   logic        word_last;

   // Reset synchroniser: assertion is immediate, release waits two clocks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n    = rst_sync[1];
   assign xfer     = rx_valid && rx_ready;
   assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   assign n_hdr    = {rx_data, len_lo};

   byte_packer #(.WIDTH(WIDTH)) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_ok),
      .accept     (xfer && (state == ST_DATA)),
      .data       (rx_data),
      .last       (word_last),
      .word_valid (mem_we),
      .word       (mem_wdata)
   );

   // Next-state decode; every transition out of a session state needs a transfer.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) state_next = ST_LEN_LO;
            else       state_next = state;
         end
         ST_LEN_LO: begin
            if (xfer) state_next = ST_LEN_HI;
            else      state_next = state;
         end
         ST_LEN_HI: begin
            if (!xfer)                                  state_next = state;
            else if ((n_hdr == 16'd0) || (n_hdr > SIZE_W)) state_next = ST_ERR;
            else                                        state_next = ST_DATA;
         end
         ST_DATA: begin
            // word_last already implies a transfer in DATA
            if (word_last && (word_idx == (n_words - 16'd1))) state_next = ST_CSUM;
            else                                           state_next = state;
         end
         ST_CSUM: begin
            if (!xfer)               state_next = state;
            else if (rx_data == csum) state_next = ST_DONE;
            else                     state_next = ST_ERR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register with status outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rx_ready <= 1'b0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state    <= state_next;
         rx_ready <= rx_open(state_next);
         cpu_hold <= (state_next != ST_DONE);
         done     <= (state_next == ST_DONE);
         error    <= (state_next == ST_ERR);
      end
   end

   // Header capture, checksum, word index and write address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo   <= 8'd0;
         n_words  <= 16'd0;
         word_idx <= 16'd0;
         csum     <= 8'd0;
         mem_addr <= '0;
      end else if (start_ok) begin
         word_idx <= 16'd0;
         csum     <= 8'd0;
      end else begin
         if (xfer && (state == ST_LEN_LO)) len_lo  <= rx_data;
         if (xfer && (state == ST_LEN_HI)) n_words <= n_hdr;
         if (xfer && (state == ST_DATA))   csum    <= csum ^ rx_data;
         // Address is registered alongside the assembled word so both
         // appear together in the write cycle and hold afterwards.
         if (word_last) begin
            mem_addr <= WIDTH'({word_idx, 2'b00});
            word_idx <= word_idx + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as
// stimulus is issued; a negedge monitor pops and compares on every mem_we.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] stim [0:15];

   imem_loader #(.WIDTH(32), .SIZE(102)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Write monitor and done/error exclusivity check.
   always @(negedge clk) begin
      wr_t e;
      if (mem_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               failures++;
               $display("FAIL write actual=%h/%h expected=%h/%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
      if (done === 1'b1 && error === 1'b1) begin
         checks++;
         failures++;
         $display("FAIL done_and_error both high");
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic load_std(input logic [7:0] cs);
      logic [7:0] s [0:10];
      s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      for (int i = 0; i < 11; i++) stim[i] = s[i];
      stim[10] = cs;
   endtask

   task automatic push_write(input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic push_std();
      push_write(32'h0000_0000, 32'h4433_2211);
      push_write(32'h0000_0004, 32'h8877_6655);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_after_start", {31'd0, rx_ready}, 32'd1);
      check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
   endtask

   // Send stim[0..n-1]; stop_at returns before that index; gap idles between bytes.
   task automatic send(input int n, input int gap, input int stop_at);
      int t;
      for (int i = 0; i < n; i++) begin
         if (i == stop_at) return;
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = stim[i];
         t = 0;
         while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t == 20) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout byte=%0d actual=%b expected=1", i, rx_ready);
         end
         @(posedge clk);
         if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic end_state(input string name, input logic exp_done, input logic exp_err);
      repeat (2) @(negedge clk);
      check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
      check({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
      check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, ~exp_done});
      check({name, "_ready"}, {31'd0, rx_ready}, 32'd0);
      check({name, "_pending"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_ready"}, {31'd0, rx_ready}, 32'd0);
      check({name, "_we"}, {31'd0, mem_we}, 32'd0);
      check({name, "_addr"}, mem_addr, 32'd0);
      check({name, "_wdata"}, mem_wdata, 32'd0);
      check({name, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      check({name, "_done"}, {31'd0, done}, 32'd0);
      check({name, "_error"}, {31'd0, error}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      release_reset();
      check("idle_ready", {31'd0, rx_ready}, 32'd0);

      // good load, checksum 0x88
      load_std(8'h88);
      pulse_start();
      push_std();
      send(11, 0, -1);
      end_state("good", 1'b1, 1'b0);
      check("hold_addr", mem_addr, 32'h0000_0004);
      check("hold_wdata", mem_wdata, 32'h8877_6655);

      // bad checksum: writes still happen, then error
      load_std(8'h00);
      pulse_start();
      push_std();
      send(11, 0, -1);
      end_state("badsum", 1'b0, 1'b1);

      // N = 103 exceeds depth
      stim[0] = 8'h67;
      stim[1] = 8'h00;
      pulse_start();
      send(2, 0, -1);
      end_state("toolong", 1'b0, 1'b1);

      // N = 0
      stim[0] = 8'h00;
      stim[1] = 8'h00;
      pulse_start();
      send(2, 0, -1);
      end_state("zero", 1'b0, 1'b1);

      // sparse valid, one byte every third cycle
      load_std(8'h88);
      pulse_start();
      push_std();
      send(11, 2, -1);
      end_state("sparse", 1'b1, 1'b0);

      // reset mid-session after header + 5 data bytes
      load_std(8'h88);
      pulse_start();
      push_write(32'h0000_0000, 32'h4433_2211);
      send(11, 0, 7);
      @(negedge clk);
      rx_valid = 1'b0;
      reset    = 1'b0;
      #1;
      check_reset_vals("midrst");
      check("midrst_pending", exp_q.size(), 32'd0);
      release_reset();
      pulse_start();
      push_std();
      send(11, 0, -1);
      end_state("after_rst", 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WIDTH, default 32: memory word width in bits; only 32 is supported.
REQ-002 Parameter SIZE, default 102: instruction memory depth in words.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_valid  input  1  byte-stream source has a valid byte.
REQ-007 rx_data  input  8  stream byte.
REQ-008 rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  WIDTH  byte address, word-aligned.
REQ-011 mem_wdata  output  WIDTH  write word.
REQ-012 cpu_hold  output  1  holds the processor in reset while high.
REQ-013 done  output  1  load completed and verified.
REQ-014 error  output  1  load rejected.

Function
REQ-015 The stream format SHALL be: LEN_LO, LEN_HI (N = {hi,lo}, in words), then 4N data bytes, then 1 checksum byte.
REQ-016 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERR.
REQ-017 start SHALL be honoured only in IDLE, DONE or ERR; it moves the FSM to LEN_LO, clears done, error, the word index and the checksum, and sets cpu_hold=1.
REQ-018 start SHALL be ignored in LEN_LO, LEN_HI, DATA and CSUM.
REQ-019 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in IDLE, DONE and ERR.
REQ-020 Each state SHALL advance only on an accepted byte; a cycle without a transfer changes no state and no register.
REQ-021 After LEN_HI is accepted, the FSM SHALL go to ERR if N==0 or N>SIZE, and otherwise to DATA.
REQ-022 In DATA, byte k (k = 0..3) of each word SHALL fill bits [8k+7:8k] of the word (little-endian).
REQ-023 mem_we SHALL be 1 for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
REQ-024 In that write cycle, mem_addr SHALL be 4*word_idx and mem_wdata the assembled word; word_idx then increments.
REQ-025 A byte accepted in the write cycle SHALL be captured into the next word without loss.
REQ-026 After the 4th byte of word N-1 is accepted, the FSM SHALL go to CSUM; the final write still occurs in the following cycle.
REQ-027 The checksum SHALL be the XOR of all 4N data bytes; header bytes are excluded.
REQ-028 An accepted CSUM byte equal to the checksum SHALL move the FSM to DONE; a mismatch SHALL move it to ERR.
REQ-029 In DONE, outputs SHALL be done=1 and cpu_hold=0.
REQ-030 In ERR, outputs SHALL be error=1 and cpu_hold=1.
REQ-031 Memory writes already issued SHALL NOT be rolled back on ERR.
REQ-032 done and error SHALL never both be 1.
REQ-033 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-034 Reset low SHALL asynchronously force state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0 and error=0.
REQ-035 Reset SHALL also clear the byte count, the word index and the checksum.
REQ-036 Reset asserted mid-session SHALL abort the session; memory contents are left as written.
REQ-037 Release of reset SHALL be synchronised into clk before it can affect the FSM.

Structure
REQ-038 A package loader_pkg SHALL hold the state enum, WORD_BYTES=4 and HDR_BYTES=2.
REQ-039 One sub-module, byte_packer, SHALL hold the byte counter, word assembly and the word-complete pulse; the FSM, word index and checksum stay in imem_loader.

Verification
REQ-040 Scenario: start; send 02 00 11 22 33 44 55 66 77 88, checksum 88 -> writes (0x0, 0x44332211) and (0x4, 0x88776655); then done=1, cpu_hold=0.
REQ-041 Scenario: same stream, checksum 00 -> the same two writes occur, then error=1, cpu_hold=1, done=0.
REQ-042 Scenario: header 67 00 (N=103 > SIZE) -> ERR after the 2nd byte; no mem_we; rx_ready=0.
REQ-043 Scenario: header 00 00 -> ERR; no mem_we.
REQ-044 Scenario: the REQ-040 stream with rx_valid high only every 3rd cycle -> identical writes and done=1.
REQ-045 Scenario: reset low after 5 data bytes -> all outputs at reset values; a fresh start with the REQ-040 stream -> correct writes and done=1.
